// File: rtl/fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ext
// Brief    : Single-clock FIFO, any depth, registered-read or FWFT output,
//            programmable almost flags and sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      w_ptr;
    logic [PTR_W-1:0]      r_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flush suppresses both ports so nothing is stored or popped that cycle.
    assign wr_ok = wr_en && !full  && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) w_ptr <= next_ptr(w_ptr);
            if (rd_ok) r_ptr <= next_ptr(r_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full  && !flush);
            underflow <= (underflow && !clr_err) || (rd_en && empty && !flush);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[w_ptr] <= wdata;
    end

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = empty ? '0 : mem[r_ptr];
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst)        rdata <= '0;
                else if (rd_ok) rdata <= mem[r_ptr];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ext
// Brief    : Four fifo_ext configurations on shared stimulus, checked against
//            queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ext;

    logic clk = 1'b0;
    logic rst, flush, wr_en, rd_en, clr_err;
    logic [7:0] wdata;

    logic [3:0][7:0] rd_p;
    logic [2:0] c0, c1, c2;
    logic [3:0] c3;
    logic [3:0][3:0] cnt_p;
    logic [3:0] full_v, empty_v, af_v, ae_v, ovf_v, unf_v;

    assign cnt_p[0] = {1'b0, c0};
    assign cnt_p[1] = {1'b0, c1};
    assign cnt_p[2] = {1'b0, c2};
    assign cnt_p[3] = c3;

    always #5 clk = ~clk;

    // dut0: DEPTH=4 registered, dut1: DEPTH=5, dut2: DEPTH=4 FWFT, dut3: DEPTH=8 thresholds 6/2
    fifo_ext #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rd_p[0]), .full(full_v[0]), .empty(empty_v[0]), .almost_full(af_v[0]),
        .almost_empty(ae_v[0]), .count(c0), .overflow(ovf_v[0]), .underflow(unf_v[0]),
        .clr_err(clr_err));
    fifo_ext #(.DATA_WIDTH(8), .DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rd_p[1]), .full(full_v[1]), .empty(empty_v[1]), .almost_full(af_v[1]),
        .almost_empty(ae_v[1]), .count(c1), .overflow(ovf_v[1]), .underflow(unf_v[1]),
        .clr_err(clr_err));
    fifo_ext #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rd_p[2]), .full(full_v[2]), .empty(empty_v[2]), .almost_full(af_v[2]),
        .almost_empty(ae_v[2]), .count(c2), .overflow(ovf_v[2]), .underflow(unf_v[2]),
        .clr_err(clr_err));
    fifo_ext #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_d8 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rd_p[3]), .full(full_v[3]), .empty(empty_v[3]), .almost_full(af_v[3]),
        .almost_empty(ae_v[3]), .count(c3), .overflow(ovf_v[3]), .underflow(unf_v[3]),
        .clr_err(clr_err));

    int total = 0;
    int bad   = 0;

    int mdepth [4] = '{4, 5, 4, 8};
    int mfwft  [4] = '{0, 0, 1, 0};
    int maf    [4] = '{2, 3, 2, 6};
    int mae    [4] = '{2, 2, 2, 2};
    logic [7:0] mq [4][$];
    logic [7:0] mrd [4];
    logic       movf [4];
    logic       munf [4];

    // Reference behaviour: a queue per FIFO, updated from the inputs seen at the edge.
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int  sz;
            logic is_full, is_empty;
            sz       = mq[k].size();
            is_full  = (sz == mdepth[k]);
            is_empty = (sz == 0);
            if (rst) begin
                mq[k].delete();
                mrd[k]  = 8'h00;
                movf[k] = 1'b0;
                munf[k] = 1'b0;
            end else if (flush) begin
                mq[k].delete();
                movf[k] = movf[k] && !clr_err;
                munf[k] = munf[k] && !clr_err;
            end else begin
                if (rd_en && !is_empty) begin
                    logic [7:0] h;
                    h = mq[k].pop_front();
                    if (mfwft[k] == 0) mrd[k] = h;
                end
                if (wr_en && !is_full) mq[k].push_back(wdata);
                movf[k] = (movf[k] && !clr_err) || (wr_en && is_full);
                munf[k] = (munf[k] && !clr_err) || (rd_en && is_empty);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic w, input logic rd,
                         input logic [7:0] d, input logic c);
        rst = r; flush = f; wr_en = w; rd_en = rd; wdata = d; clr_err = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [5:0] got;
            got = {cnt_p[k] == 4'd0, empty_v[k], full_v[k], ae_v[k], af_v[k], ovf_v[k] | unf_v[k]};
            total++;
            if (got !== 6'b110100) begin
                bad++;
                $display("FAIL reset_flags dut%0d got=%b exp=110100", k, got);
            end
            if (mfwft[k] == 0) begin
                total++;
                if (rd_p[k] !== 8'h00) begin
                    bad++;
                    $display("FAIL reset_rdata dut%0d got=%h exp=00", k, rd_p[k]);
                end
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        total++;
        if (full_v[0] !== 1'b1 || c0 !== 3'd4) begin
            bad++;
            $display("FAIL fill_full got full=%b count=%0d exp full=1 count=4", full_v[0], c0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
        total++;
        if (ovf_v[0] !== 1'b1 || c0 !== 3'd4) begin
            bad++;
            $display("FAIL fill_overflow got ovf=%b count=%0d exp ovf=1 count=4", ovf_v[0], c0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            total++;
            if (rd_p[0] !== 8'hA0 + 8'(i)) begin
                bad++;
                $display("FAIL fill_readback i=%0d got=%h exp=%h", i, rd_p[0], 8'hA0 + 8'(i));
            end
        end
        total++;
        if (empty_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL fill_empty got=%b exp=1", empty_v[0]);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h13 + 8'(i), 1'b0);
            total++;
            if (c1 !== 3'd3 || rd_p[1] !== 8'h10 + 8'(i)) begin
                bad++;
                $display("FAIL wrap_d5 i=%0d got count=%0d data=%h exp count=3 data=%h",
                         i, c1, rd_p[1], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
        total++;
        if (c0 !== 3'd3 || ovf_v[0] !== 1'b1 || rd_p[0] !== 8'h20) begin
            bad++;
            $display("FAIL simul_full got count=%0d ovf=%b data=%h exp count=3 ovf=1 data=20",
                     c0, ovf_v[0], rd_p[0]);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h24, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1);
        total++;
        if (ovf_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_clear got ovf=%b exp=1", ovf_v[0]);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (ovf_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL clr_err got ovf=%b exp=0", ovf_v[0]);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        total++;
        if (c0 !== 3'd1 || unf_v[0] !== 1'b1 || ovf_v[0] !== 1'b0 || rd_p[0] !== 8'h20) begin
            bad++;
            $display("FAIL simul_empty got count=%0d unf=%b ovf=%b data=%h exp 1 1 0 20",
                     c0, unf_v[0], ovf_v[0], rd_p[0]);
        end
    endtask

    task automatic test_fwft();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        total++;
        if (empty_v[2] !== 1'b0 || rd_p[2] !== 8'h5A) begin
            bad++;
            $display("FAIL fwft_show got empty=%b data=%h exp empty=0 data=5a", empty_v[2], rd_p[2]);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        total++;
        if (empty_v[2] !== 1'b1) begin
            bad++;
            $display("FAIL fwft_pop got empty=%b exp=1", empty_v[2]);
        end
    endtask

    task automatic test_thresholds();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int n = 0; n <= 8; n++) begin
            if (n > 0) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'(n), 1'b0);
            total++;
            if (c3 !== 4'(n) || ae_v[3] !== (n <= 2) || af_v[3] !== (n >= 6)) begin
                bad++;
                $display("FAIL thresh n=%0d got count=%0d ae=%b af=%b exp ae=%b af=%b",
                         n, c3, ae_v[3], af_v[3], n <= 2, n >= 6);
            end
        end
    endtask

    task automatic test_flush_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b0);
        total++;
        if (c0 !== 3'd0 || empty_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL flush_wr got count=%0d empty=%b ovf=%b exp 0 1 0", c0, empty_v[0], ovf_v[0]);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        total++;
        if (ovf_v[0] !== 1'b1 || rd_p[0] !== 8'h40) begin
            bad++;
            $display("FAIL pre_reset got ovf=%b data=%h exp ovf=1 data=40", ovf_v[0], rd_p[0]);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (ovf_v[0] !== 1'b0 || rd_p[0] !== 8'h00 || c0 !== 3'd0) begin
            bad++;
            $display("FAIL reset_clears got ovf=%b data=%h count=%0d exp 0 00 0", ovf_v[0], rd_p[0], c0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            logic bias;
            bias = ((c / 60) % 2) == 1;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0,
                  $urandom_range(0, 99) < (bias ? 75 : 30),
                  $urandom_range(0, 99) < (bias ? 30 : 75),
                  8'($urandom), $urandom_range(0, 24) == 0);
            for (int k = 0; k < 4; k++) begin
                int sz;
                logic [5:0] exp_f, got_f;
                sz    = mq[k].size();
                exp_f = {sz == mdepth[k], sz == 0, sz >= maf[k], sz <= mae[k], movf[k], munf[k]};
                got_f = {full_v[k], empty_v[k], af_v[k], ae_v[k], ovf_v[k], unf_v[k]};
                total++;
                if (cnt_p[k] !== 4'(sz) || got_f !== exp_f) begin
                    bad++;
                    $display("FAIL rnd_status dut%0d cyc%0d got count=%0d flags=%b exp count=%0d flags=%b",
                             k, c, cnt_p[k], got_f, sz, exp_f);
                end
                if (mfwft[k] == 0 || sz > 0) begin
                    logic [7:0] exp_d;
                    exp_d = (mfwft[k] != 0) ? mq[k][0] : mrd[k];
                    total++;
                    if (rd_p[k] !== exp_d) begin
                        bad++;
                        $display("FAIL rnd_rdata dut%0d cyc%0d got=%h exp=%h", k, c, rd_p[k], exp_d);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00; clr_err = 1'b0;
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_thresholds();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ext.md
FIFO_EXT -- requirements
Module: fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2; non-power-of-2 legal).
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost_full level (legal 1..DEPTH).
REQ-005 SHALL have parameter AEMPTY_THRESH, default 2, almost_empty level (legal 0..DEPTH-1).
REQ-006 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have: flush  input  1  synchronous clear of contents, sticky flags kept.
REQ-009 SHALL have: wr_en  input  1  write request.
REQ-010 SHALL have: wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have: rd_en  input  1  read (pop) request.
REQ-012 SHALL have: rdata  output  DATA_WIDTH  read data.
REQ-013 SHALL have: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have: count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have: overflow, underflow  output  1 each  sticky error flags.
REQ-016 SHALL have: clr_err  input  1  clears overflow/underflow.

Function
REQ-017 Write SHALL be accepted iff wr_en && !full; accepted data stored at w_ptr, w_ptr advances.
REQ-018 Read SHALL be accepted iff rd_en && !empty; r_ptr advances.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH (no power-of-2 reliance).
REQ-020 count SHALL update next cycle: +1 write-only accepted, -1 read-only accepted, unchanged if both or neither.
REQ-021 When full, a write SHALL be rejected even if a read is accepted the same cycle.
REQ-022 When empty, a read SHALL be rejected even if a write is accepted the same cycle.
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_THRESH); almost_empty = (count<=AEMPTY_THRESH); all combinational from registered count.
REQ-024 FWFT=0: on accepted read, rdata SHALL present the head entry one cycle later and hold it until the next accepted read.
REQ-025 FWFT=1: whenever !empty, rdata SHALL present the head entry in the same cycle; rd_en pops it; rdata value while empty is unspecified.
REQ-026 Data SHALL leave in exact write order; no entry lost, duplicated or reordered.
REQ-027 overflow SHALL set on the cycle after wr_en && full; underflow on the cycle after rd_en && empty; both remain set until clr_err or rst.
REQ-028 If clr_err and a new error event coincide, the flag SHALL be set (set wins).
REQ-029 flush SHALL zero w_ptr, r_ptr, count next cycle; it overrides wr_en/rd_en in the same cycle (no write stored, no error flagged); rdata unchanged; memory contents not cleared.

Reset
REQ-030 On rst high at a clock edge: w_ptr=0, r_ptr=0, count=0, rdata=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 rst SHALL take priority over flush, clr_err, wr_en, rd_en; reset mid-operation discards all contents.
REQ-032 Memory array SHALL not require reset.

Verification
REQ-033 DEPTH=4, FWFT=0: write A,B,C,D -> full=1, count=4; 5th write -> rejected, overflow=1; four reads -> rdata A,B,C,D on cycles after each pop, empty=1.
REQ-034 DEPTH=5 (non-pow2): 12 writes interleaved with reads keeping count 3 -> pointers wrap, output order equals input order, count stays 3.
REQ-035 Full with simultaneous wr_en+rd_en -> read accepted, write rejected, count 4->3, overflow=1; empty with both -> write accepted, count 0->1, underflow=1.
REQ-036 FWFT=1: write 0x5A into empty -> next cycle empty=0, rdata=0x5A with no rd_en; rd_en -> empty=1.
REQ-037 DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2: fill 0..8 -> almost_empty 1 for count<=2, almost_full 1 for count>=6.
REQ-038 Count 3, flush with wr_en -> count=0, empty=1, no overflow; then rst with overflow set -> overflow=0, rdata=0.
